// File: rtl/disparity_scheduler_pkg.sv
// disparity_scheduler_pkg: shared stereo FSM encoding and default widths
// used by the disparity sweep scheduler and its compare logic.
package disparity_scheduler_pkg;
   localparam int WS_W_DEF   = 14;
   localparam int DISP_W_DEF = 6;
   localparam int COL_W      = 10;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, EMIT} state_t;
endpackage

// File: rtl/disparity_scheduler_ws_min4.sv
// ws_min4: four-lane minimum over unmasked window sums; ties go to the lower lane.
module ws_min4
   import disparity_scheduler_pkg::*;
#(
   parameter int WS_W = WS_W_DEF
) (
   input  logic [3:0][WS_W-1:0] i_ws,
   input  logic [3:0]           i_mask,
   output logic                 o_any,
   output logic [WS_W-1:0]      o_min,
   output logic [1:0]           o_idx
);
   logic            w_lo_v, w_hi_v, w_lo_b, w_hi_b, w_take_hi;
   logic [WS_W-1:0] w_lo_ws, w_hi_ws;
   // pairwise tree: the right operand wins only when strictly smaller
   always_comb begin
      w_lo_v    = !(i_mask[0] && i_mask[1]);
      w_hi_v    = !(i_mask[2] && i_mask[3]);
      w_lo_b    = !i_mask[1] && (i_mask[0] || i_ws[1] < i_ws[0]);
      w_hi_b    = !i_mask[3] && (i_mask[2] || i_ws[3] < i_ws[2]);
      w_lo_ws   = w_lo_b ? i_ws[1] : i_ws[0];
      w_hi_ws   = w_hi_b ? i_ws[3] : i_ws[2];
      w_take_hi = w_hi_v && (!w_lo_v || w_hi_ws < w_lo_ws);
      o_any     = w_lo_v || w_hi_v;
      o_min     = w_take_hi ? w_hi_ws : w_lo_ws;
      o_idx     = w_take_hi ? {1'b1, w_hi_b} : {1'b0, w_lo_b};
   end
endmodule

// File: rtl/disparity_scheduler.sv
// disparity_scheduler: sweeps disparity groups per column through four pipelines
// and returns the per-column winning disparity over a valid/ready handshake.
module disparity_scheduler
   import disparity_scheduler_pkg::*;
#(
   parameter int NUM_GROUPS   = 16,
   parameter int PIPE_LATENCY = 8,
   parameter int WS_W         = WS_W_DEF,
   parameter int DISP_W       = DISP_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read_start,
   input  logic [COL_W-1:0]  line_width,
   input  logic [WS_W-1:0]   ws1,
   input  logic [WS_W-1:0]   ws2,
   input  logic [WS_W-1:0]   ws3,
   input  logic [WS_W-1:0]   ws4,
   output logic [COL_W-1:0]  col_addr,
   output logic [DISP_W-1:0] disparity_1,
   output logic [DISP_W-1:0] disparity_2,
   output logic [DISP_W-1:0] disparity_3,
   output logic [DISP_W-1:0] disparity_4,
   output logic              issue_valid,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [DISP_W-1:0] result_disparity,
   output logic [WS_W-1:0]   result_ws,
   output logic              busy,
   output logic              done,
   output logic              overrun
);
   localparam int GW = NUM_GROUPS > 1 ? $clog2(NUM_GROUPS) : 1;
   typedef struct packed {
      logic          v;
      logic [GW-1:0] g;
      logic [3:0]    mask;
   } dl_t;
   state_t                   r_state, w_next;
   dl_t [PIPE_LATENCY-1:0]   r_dl;
   dl_t                      w_dl_in, w_dl_out;
   logic [COL_W-1:0]         r_col, r_width;
   logic [GW-1:0]            r_group;
   logic [WS_W-1:0]          r_min, w_min;
   logic [DISP_W-1:0]        r_mind;
   logic                     r_last_cmp, r_done, r_overrun;
   logic [3:0][DISP_W-1:0]   w_disp;
   logic [1:0]               w_idx;
   logic                     w_any, w_accept, w_last_col, w_last_group, w_better, w_enter;
   ws_min4 #(.WS_W(WS_W)) u_min (
      .i_ws   ({ws4, ws3, ws2, ws1}),
      .i_mask (w_dl_out.mask),
      .o_any  (w_any),
      .o_min  (w_min),
      .o_idx  (w_idx)
   );
   always_comb begin
      w_dl_in.v    = issue_valid;
      w_dl_in.g    = r_group;
      w_dl_in.mask = '0;
      for (int k = 0; k < 4; k++) begin
         w_disp[k]       = issue_valid ? DISP_W'(4 * int'(r_group) + k) : '0;
         w_dl_in.mask[k] = 4 * int'(r_group) + k > int'(r_col);
      end
   end
   assign w_dl_out     = r_dl[PIPE_LATENCY-1];
   assign w_accept     = read_start && r_state == IDLE;
   assign w_last_col   = r_col == r_width - 1'b1;
   assign w_last_group = r_group == GW'(NUM_GROUPS - 1);
   assign w_better     = w_dl_out.v && w_any && w_min < r_min;
   assign w_enter      = w_next == ISSUE && r_state != ISSUE;
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = w_accept && line_width != '0 ? ISSUE : IDLE;
         ISSUE:   w_next = w_last_group ? DRAIN : ISSUE;
         DRAIN:   w_next = r_last_cmp ? EMIT : DRAIN;
         EMIT:    w_next = !result_ready ? EMIT : w_last_col ? IDLE : ISSUE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_dl       <= '0;
         r_col      <= '0;
         r_width    <= '0;
         r_group    <= '0;
         r_min      <= '0;
         r_mind     <= '0;
         r_last_cmp <= 1'b0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_dl[0]    <= w_dl_in;
         for (int i = 1; i < PIPE_LATENCY; i++) r_dl[i] <= r_dl[i-1];
         r_last_cmp <= w_dl_out.v && w_dl_out.g == GW'(NUM_GROUPS - 1);
         r_done     <= (w_accept && line_width == '0) || (r_state == EMIT && result_ready && w_last_col);
         r_overrun  <= read_start && r_state != IDLE;
         if (w_accept) r_width <= line_width;
         // each new column restarts the search from all-ones at disparity 0
         if (w_enter) begin
            r_col   <= r_state == IDLE ? '0 : r_col + 1'b1;
            r_group <= '0;
            r_min   <= '1;
            r_mind  <= '0;
         end else begin
            if (r_state == ISSUE) r_group <= r_group + 1'b1;
            if (w_better) begin
               r_min  <= w_min;
               r_mind <= DISP_W'(4 * int'(w_dl_out.g) + int'(w_idx));
            end
         end
      end
   end
   assign col_addr         = r_col;
   assign disparity_1      = w_disp[0];
   assign disparity_2      = w_disp[1];
   assign disparity_3      = w_disp[2];
   assign disparity_4      = w_disp[3];
   assign issue_valid      = r_state == ISSUE;
   assign result_valid     = r_state == EMIT;
   assign result_disparity = r_mind;
   assign result_ws        = r_min;
   assign busy             = r_state != IDLE;
   assign done             = r_done;
   assign overrun          = r_overrun;
endmodule
